// File: rtl/interboard_pkg.sv
// Shared definitions for the interboard transmit queue: message field widths,
// the packed message layout, FSM state encoding and pack/unpack helpers.
package interboard_pkg;

    localparam int DIR_W  = 1;
    localparam int BX_W   = 5;
    localparam int BY_W   = 3;
    localparam int MT_W   = 4;
    localparam int CARD_W = 6;
    localparam int SL_W   = 3;
    localparam int MSG_W  = DIR_W + BX_W + BY_W + MT_W + CARD_W + SL_W;

    // Field order matches the wire packing, MSB first.
    typedef struct packed {
        logic [DIR_W-1:0]  move_dir;
        logic [BX_W-1:0]   block_x;
        logic [BY_W-1:0]   block_y;
        logic [MT_W-1:0]   msg_type;
        logic [CARD_W-1:0] card;
        logic [SL_W-1:0]   sel_len;
    } msg_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    function automatic logic [MSG_W-1:0] pack_msg(input msg_t m);
        return {m.move_dir, m.block_x, m.block_y, m.msg_type, m.card, m.sel_len};
    endfunction

    function automatic msg_t unpack_msg(input logic [MSG_W-1:0] v);
        msg_t m;
        {m.move_dir, m.block_x, m.block_y, m.msg_type, m.card, m.sel_len} = v;
        return m;
    endfunction

endpackage

// File: rtl/interboard_tx_queue_if.sv
// Bundle between GameControl / the communication top (master side) and the
// transmit queue (slave side). DEPTH must match the queue instance.
interface interboard_tx_queue_if
    import interboard_pkg::*;
#(
    parameter int DEPTH = 4
) ();

    logic                   interboard_rst;
    logic                   transmit;
    logic                   inter_ready;

    logic                   push_en;
    logic [DIR_W-1:0]       push_move_dir;
    logic [BX_W-1:0]        push_block_x;
    logic [BY_W-1:0]        push_block_y;
    logic [MT_W-1:0]        push_msg_type;
    logic [CARD_W-1:0]      push_card;
    logic [SL_W-1:0]        push_sel_len;

    logic                   ctrl_en;
    logic [DIR_W-1:0]       ctrl_move_dir;
    logic [BX_W-1:0]        ctrl_block_x;
    logic [BY_W-1:0]        ctrl_block_y;
    logic [MT_W-1:0]        ctrl_msg_type;
    logic [CARD_W-1:0]      ctrl_card;
    logic [SL_W-1:0]        ctrl_sel_len;

    logic [$clog2(DEPTH):0] q_count;
    logic                   q_full;
    logic                   q_empty;
    logic                   overflow;

    modport master (
        output interboard_rst, transmit, inter_ready,
        output push_en, push_move_dir, push_block_x, push_block_y,
        output push_msg_type, push_card, push_sel_len,
        input  ctrl_en, ctrl_move_dir, ctrl_block_x, ctrl_block_y,
        input  ctrl_msg_type, ctrl_card, ctrl_sel_len,
        input  q_count, q_full, q_empty, overflow
    );

    modport slave (
        input  interboard_rst, transmit, inter_ready,
        input  push_en, push_move_dir, push_block_x, push_block_y,
        input  push_msg_type, push_card, push_sel_len,
        output ctrl_en, ctrl_move_dir, ctrl_block_x, ctrl_block_y,
        output ctrl_msg_type, ctrl_card, ctrl_sel_len,
        output q_count, q_full, q_empty, overflow
    );

endinterface

// File: rtl/interboard_msg_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued messages.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// A push while full is accepted only when a pop happens in the same cycle.
module interboard_msg_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic                   clk,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign pop_ok_s  = pop & ~empty_r;
    assign push_ok_s = push & (~full_r | pop_ok_s);

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_r;
    assign empty = empty_r;

    // Storage write; a flush cycle never stores data.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and the registered full/empty flags.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    count_r <= count_r + CNT_W'(1);
                    full_r  <= (count_r == CNT_W'(DEPTH - 1));
                    empty_r <= 1'b0;
                end
                2'b01: begin
                    count_r <= count_r - CNT_W'(1);
                    full_r  <= 1'b0;
                    empty_r <= (count_r == CNT_W'(1));
                end
                default: begin
                    count_r <= count_r;
                    full_r  <= full_r;
                    empty_r <= empty_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/interboard_tx_queue.sv
// Transmit queue between GameControl and the interboard communication top.
// Messages are buffered in a FIFO and issued one at a time with a single
// ctrl_en strobe; the head entry is popped once the sender has gone busy and
// come back idle, or when it never went busy within BUSY_TIMEOUT cycles.
module interboard_tx_queue
    import interboard_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    interboard_tx_queue_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TO_W  = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

    logic             rst_s;
    state_t           state_r;
    state_t           state_nx_s;
    logic [TO_W-1:0]  to_cnt_r;
    logic [TO_W-1:0]  to_cnt_nx_s;
    logic             issue_s;
    logic             pop_s;
    logic             drop_s;
    msg_t             push_msg_s;
    logic [MSG_W-1:0] head_s;
    msg_t             ctrl_msg_r;
    logic             ctrl_en_r;
    logic             overflow_r;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    // Either board may request a reset; both have identical effect.
    assign rst_s = rst | bus.interboard_rst;

    assign push_msg_s.move_dir = bus.push_move_dir;
    assign push_msg_s.block_x  = bus.push_block_x;
    assign push_msg_s.block_y  = bus.push_block_y;
    assign push_msg_s.msg_type = bus.push_msg_type;
    assign push_msg_s.card     = bus.push_card;
    assign push_msg_s.sel_len  = bus.push_sel_len;

    interboard_msg_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MSG_W)
    ) u_fifo (
        .clk   (clk),
        .flush (rst_s),
        .push  (bus.push_en),
        .pop   (pop_s),
        .din   (pack_msg(push_msg_s)),
        .dout  (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // A push is lost only when the queue is full and nothing leaves this cycle.
    assign drop_s = bus.push_en & fifo_full_s & ~pop_s;

    // Next-state, timeout counter and issue/pop decisions.
    always_comb begin
        state_nx_s  = state_r;
        to_cnt_nx_s = to_cnt_r;
        issue_s     = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && bus.transmit && bus.inter_ready) begin
                    issue_s    = 1'b1;
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                to_cnt_nx_s = {TO_W{1'b0}};
                state_nx_s  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!bus.inter_ready) begin
                    state_nx_s = ST_WAIT_DONE;
                end else if (to_cnt_r == TO_LAST) begin
                    // Sender never went busy: treat the message as consumed.
                    pop_s      = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    to_cnt_nx_s = to_cnt_r + TO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (bus.inter_ready) begin
                    pop_s      = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and timeout counter registers.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            state_r  <= ST_IDLE;
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            state_r  <= state_nx_s;
            to_cnt_r <= to_cnt_nx_s;
        end
    end

    // Issue strobe and head-of-queue fields, latched only when issuing.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            ctrl_en_r  <= 1'b0;
            ctrl_msg_r <= unpack_msg({MSG_W{1'b0}});
        end else begin
            ctrl_en_r <= issue_s;
            if (issue_s) begin
                ctrl_msg_r <= unpack_msg(head_s);
            end
        end
    end

    // Sticky record of any dropped push.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign bus.ctrl_en       = ctrl_en_r;
    assign bus.ctrl_move_dir = ctrl_msg_r.move_dir;
    assign bus.ctrl_block_x  = ctrl_msg_r.block_x;
    assign bus.ctrl_block_y  = ctrl_msg_r.block_y;
    assign bus.ctrl_msg_type = ctrl_msg_r.msg_type;
    assign bus.ctrl_card     = ctrl_msg_r.card;
    assign bus.ctrl_sel_len  = ctrl_msg_r.sel_len;
    assign bus.q_count       = fifo_count_s;
    assign bus.q_full        = fifo_full_s;
    assign bus.q_empty       = fifo_empty_s;
    assign bus.overflow      = overflow_r;

endmodule

// File: tb/tb_interboard_tx_queue.sv
// Directed bench for interboard_tx_queue: a per-cycle vector table for the
// single-message and burst scenarios, then hand sequences for full-with-pop,
// timeout, transmit gating and interboard reset.
module tb_interboard_tx_queue;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    interboard_tx_queue_if #(.DEPTH(4)) bus ();

    interboard_tx_queue #(
        .DEPTH        (4),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pe;
        logic [21:0] msg;
        logic        tx;
        logic        rdy;
        logic        e_en;
        logic [2:0]  e_cnt;
        logic        e_full;
        logic        e_empty;
        logic        e_ovf;
        logic [21:0] e_ctrl;
    } vec_t;

    vec_t        tbl [30];
    logic [21:0] bm [5];
    logic [21:0] ma;
    logic [21:0] mm [5];

    function automatic logic [21:0] mk(input logic d, input logic [4:0] bx, input logic [2:0] by,
                                       input logic [3:0] mt, input logic [5:0] c, input logic [2:0] sl);
        return {d, bx, by, mt, c, sl};
    endfunction

    function automatic vec_t mkv(input logic pe, input logic [21:0] msg, input logic tx, input logic rdy,
                                 input logic en, input logic [2:0] cnt, input logic full, input logic empty,
                                 input logic ovf, input logic [21:0] ctrl);
        vec_t v;
        v.pe = pe; v.msg = msg; v.tx = tx; v.rdy = rdy;
        v.e_en = en; v.e_cnt = cnt; v.e_full = full; v.e_empty = empty; v.e_ovf = ovf; v.e_ctrl = ctrl;
        return v;
    endfunction

    function automatic logic [21:0] ctrl_now();
        return {bus.ctrl_move_dir, bus.ctrl_block_x, bus.ctrl_block_y,
                bus.ctrl_msg_type, bus.ctrl_card, bus.ctrl_sel_len};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic en, input logic [2:0] cnt,
                          input logic full, input logic empty, input logic ovf);
        chk({tag, ".ctrl_en"}, 32'(bus.ctrl_en), 32'(en));
        chk({tag, ".q_count"}, 32'(bus.q_count), 32'(cnt));
        chk({tag, ".q_full"}, 32'(bus.q_full), 32'(full));
        chk({tag, ".q_empty"}, 32'(bus.q_empty), 32'(empty));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(ovf));
    endtask

    // Drive one cycle of inputs, then sample just after the clock edge.
    task automatic step(input logic pe, input logic [21:0] m, input logic tx, input logic rdy);
        bus.push_en       = pe;
        bus.push_move_dir = m[21];
        bus.push_block_x  = m[20:16];
        bus.push_block_y  = m[15:13];
        bus.push_msg_type = m[12:9];
        bus.push_card     = m[8:3];
        bus.push_sel_len  = m[2:0];
        bus.transmit      = tx;
        bus.inter_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    // One issue/busy/done/pop round trip at the minimum 4-cycle spacing.
    task automatic drain_one(input string tag, input logic [21:0] exp_msg, input logic [2:0] cnt_before);
        step(1'b0, 22'd0, 1'b1, 1'b1);
        chk({tag, ".issue_en"}, 32'(bus.ctrl_en), 32'd1);
        chk({tag, ".issue_ctrl"}, 32'(ctrl_now()), 32'(exp_msg));
        step(1'b0, 22'd0, 1'b1, 1'b0);
        chk({tag, ".en_one_cycle"}, 32'(bus.ctrl_en), 32'd0);
        step(1'b0, 22'd0, 1'b1, 1'b0);
        chk({tag, ".wait_en"}, 32'(bus.ctrl_en), 32'd0);
        chk({tag, ".wait_count"}, 32'(bus.q_count), 32'(cnt_before));
        step(1'b0, 22'd0, 1'b1, 1'b1);
        chk({tag, ".pop_count"}, 32'(bus.q_count), 32'(cnt_before - 3'd1));
        chk({tag, ".hold_ctrl"}, 32'(ctrl_now()), 32'(exp_msg));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        bus.interboard_rst = 1'b0;
        rst = 1'b1;

        ma    = mk(1'b1, 5'd17, 3'd5, 4'd3, 6'd42, 3'd2);
        bm[0] = mk(1'b0, 5'd1,  3'd1, 4'd1, 6'd1,  3'd1);
        bm[1] = mk(1'b1, 5'd2,  3'd2, 4'd2, 6'd2,  3'd2);
        bm[2] = mk(1'b0, 5'd3,  3'd3, 4'd3, 6'd3,  3'd3);
        bm[3] = mk(1'b1, 5'd4,  3'd4, 4'd4, 6'd4,  3'd4);
        bm[4] = mk(1'b0, 5'd31, 3'd7, 4'd15, 6'd63, 3'd7);
        mm[0] = mk(1'b1, 5'd10, 3'd0, 4'd9,  6'd11, 3'd5);
        mm[1] = mk(1'b0, 5'd11, 3'd6, 4'd8,  6'd12, 3'd4);
        mm[2] = mk(1'b1, 5'd12, 3'd1, 4'd7,  6'd13, 3'd3);
        mm[3] = mk(1'b0, 5'd13, 3'd2, 4'd6,  6'd14, 3'd6);
        mm[4] = mk(1'b1, 5'd14, 3'd3, 4'd5,  6'd15, 3'd1);

        // Single message: issue one cycle after push, busy, done, pop.
        tbl[0] = mkv(1'b1, ma,    1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 22'd0);
        tbl[1] = mkv(1'b0, 22'd0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, ma);
        tbl[2] = mkv(1'b0, 22'd0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, ma);
        tbl[3] = mkv(1'b0, 22'd0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, ma);
        tbl[4] = mkv(1'b0, 22'd0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, ma);
        tbl[5] = mkv(1'b0, 22'd0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, ma);
        tbl[6] = mkv(1'b0, 22'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, ma);
        tbl[7] = mkv(1'b0, 22'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, ma);
        // Burst of 5 with the sender busy: 4 stored, 5th dropped.
        for (int k = 0; k < 5; k++) begin
            tbl[8 + k] = mkv(1'b1, bm[k], 1'b1, 1'b0, 1'b0, (k < 4) ? 3'(k + 1) : 3'd4,
                             (k >= 3), 1'b0, (k == 4), ma);
        end
        // Drain in FIFO order, one issue every 4 cycles.
        for (int k = 0; k < 4; k++) begin
            tbl[13 + 4 * k] = mkv(1'b0, 22'd0, 1'b1, 1'b1, 1'b1, 3'(4 - k), (k == 0), 1'b0, 1'b1, bm[k]);
            tbl[14 + 4 * k] = mkv(1'b0, 22'd0, 1'b1, 1'b0, 1'b0, 3'(4 - k), (k == 0), 1'b0, 1'b1, bm[k]);
            tbl[15 + 4 * k] = mkv(1'b0, 22'd0, 1'b1, 1'b0, 1'b0, 3'(4 - k), (k == 0), 1'b0, 1'b1, bm[k]);
            tbl[16 + 4 * k] = mkv(1'b0, 22'd0, 1'b1, 1'b1, 1'b0, 3'(3 - k), 1'b0, (k == 3), 1'b1, bm[k]);
        end
        tbl[29] = mkv(1'b0, 22'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, bm[3]);

        // Reset state.
        step(1'b1, ma, 1'b1, 1'b1);
        step(1'b0, 22'd0, 1'b1, 1'b1);
        chk_st("reset", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("reset.ctrl", 32'(ctrl_now()), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            step(tbl[i].pe, tbl[i].msg, tbl[i].tx, tbl[i].rdy);
            chk_st($sformatf("vec%0d", i), tbl[i].e_en, tbl[i].e_cnt, tbl[i].e_full,
                   tbl[i].e_empty, tbl[i].e_ovf);
            chk($sformatf("vec%0d.ctrl", i), 32'(ctrl_now()), 32'(tbl[i].e_ctrl));
        end
        chk("single.block_x", 32'(bus.ctrl_block_x), 32'd4);

        // Push while full on the pop cycle is accepted.
        rst = 1'b1;
        step(1'b0, 22'd0, 1'b1, 1'b0);
        rst = 1'b0;
        chk_st("rst2", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, mm[k], 1'b1, 1'b0);
        chk_st("fill", 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
        step(1'b0, 22'd0, 1'b1, 1'b1);
        chk("fullpop.issue", 32'(ctrl_now()), 32'(mm[0]));
        step(1'b0, 22'd0, 1'b1, 1'b0);
        step(1'b0, 22'd0, 1'b1, 1'b0);
        step(1'b1, mm[4], 1'b1, 1'b1);
        chk_st("fullpop", 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 5; k++) drain_one($sformatf("fp%0d", k), mm[k], 3'(5 - k));
        chk_st("fp.end", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Timeout: sender never goes busy.
        step(1'b1, bm[0], 1'b1, 1'b0);
        step(1'b1, bm[1], 1'b1, 1'b0);
        step(1'b0, 22'd0, 1'b1, 1'b1);
        chk("to.issue0", 32'(bus.ctrl_en), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 22'd0, 1'b1, 1'b1);
            chk_st($sformatf("to.wait%0d", k), 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 22'd0, 1'b1, 1'b1);
        chk_st("to.pop", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 22'd0, 1'b1, 1'b1);
        chk("to.issue1", 32'(bus.ctrl_en), 32'd1);
        chk("to.ctrl1", 32'(ctrl_now()), 32'(bm[1]));
        for (int k = 0; k < 5; k++) step(1'b0, 22'd0, 1'b1, 1'b1);
        chk_st("to.end", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // transmit low: hold while queued; then issue 4 apart; no resend when
        // transmit drops mid-flight.
        step(1'b1, mm[2], 1'b0, 1'b1);
        step(1'b1, mm[3], 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 22'd0, 1'b0, 1'b1);
            chk($sformatf("tx0.hold%0d.en", k), 32'(bus.ctrl_en), 32'd0);
            chk($sformatf("tx0.hold%0d.cnt", k), 32'(bus.q_count), 32'd2);
        end
        drain_one("tx1.a", mm[2], 3'd2);
        step(1'b0, 22'd0, 1'b1, 1'b1);
        chk("tx1.b.en", 32'(bus.ctrl_en), 32'd1);
        chk("tx1.b.ctrl", 32'(ctrl_now()), 32'(mm[3]));
        step(1'b0, 22'd0, 1'b0, 1'b0);
        step(1'b0, 22'd0, 1'b0, 1'b0);
        step(1'b0, 22'd0, 1'b0, 1'b1);
        chk_st("tx1.b.pop", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 22'd0, 1'b1, 1'b1);
            chk($sformatf("tx1.noresend%0d", k), 32'(bus.ctrl_en), 32'd0);
        end

        // interboard_rst during WAIT_DONE with 3 queued, overflow set.
        for (int k = 0; k < 4; k++) step(1'b1, mm[k], 1'b1, 1'b0);
        step(1'b1, mm[4], 1'b1, 1'b0);
        chk_st("ib.fill", 1'b0, 3'd4, 1'b1, 1'b0, 1'b1);
        drain_one("ib.d0", mm[0], 3'd4);
        step(1'b0, 22'd0, 1'b1, 1'b1);
        chk("ib.issue1", 32'(ctrl_now()), 32'(mm[1]));
        step(1'b0, 22'd0, 1'b1, 1'b0);
        step(1'b0, 22'd0, 1'b1, 1'b0);
        bus.interboard_rst = 1'b1;
        step(1'b1, mm[4], 1'b1, 1'b0);
        bus.interboard_rst = 1'b0;
        chk_st("ib.rst", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("ib.rst.ctrl", 32'(ctrl_now()), 32'd0);
        step(1'b0, 22'd0, 1'b1, 1'b0);
        chk("ib.push_discarded", 32'(bus.q_count), 32'd0);
        step(1'b1, ma, 1'b1, 1'b1);
        chk_st("ib.push", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 22'd0, 1'b1, 1'b1);
        chk("ib.issue.en", 32'(bus.ctrl_en), 32'd1);
        chk("ib.issue.ctrl", 32'(ctrl_now()), 32'(ma));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/interboard_tx_queue.md
Name: interboard_tx_queue

Overview:
- Buffers outgoing interboard messages from GameControl and drip-feeds them to the interboard communication top, one message per sender transaction.
- GameControl can post several messages back-to-back (e.g. a move followed by a card play) without waiting for the serial sender to become ready.
- Sits directly upstream of the communication top's ctrl_* inputs. Issues a one-pulse ctrl_en only when transmit and inter_ready are both high.

Parameters:
- DEPTH, 4, message slots in the queue; must be a power of 2, ≥2.
- BUSY_TIMEOUT, 4, cycles to wait after ctrl_en for inter_ready to fall before treating the message as consumed.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- interboard_rst  in  1  reset requested by other board; flushes the queue; same effect as rst
- transmit  in  1  this board owns the link; issue only while high
- inter_ready  in  1  sender idle (from communication top)
- push_en  in  1  one-pulse: enqueue the push_* fields
- push_move_dir  in  1
- push_block_x  in  5
- push_block_y  in  3
- push_msg_type  in  4
- push_card  in  6
- push_sel_len  in  3
- ctrl_en  out  1  one-pulse issue strobe to the communication top
- ctrl_move_dir, ctrl_block_x[5], ctrl_block_y[3], ctrl_msg_type[4], ctrl_card[6], ctrl_sel_len[3]  out  —  registered head-of-queue fields, stable from the ctrl_en cycle until the pop
- q_count  out  clog2(DEPTH)+1  entries held
- q_full  out  1  q_count==DEPTH
- q_empty  out  1  q_count==0
- overflow  out  1  sticky: a push was dropped

Behaviour:
- Message packed into 22 bits: {move_dir, block_x, block_y, msg_type, card, sel_len}, MSB first.
- Reset (rst or interboard_rst):
  - pointers=0, q_count=0, q_empty=1, q_full=0, overflow=0, ctrl_en=0, all ctrl_* fields=0, FSM→IDLE.
  - A message mid-issue is discarded.
  - A push in the same cycle is discarded.
- Push:
  - Accepted at the clock edge if push_en && (!q_full || pop_this_cycle).
  - push_en while full with no pop: data dropped, overflow←1 (sticky until reset).
- Pop:
  - Occurs only on the FSM transition WAIT_DONE→IDLE or WAIT_BUSY→IDLE (timeout).
  - Push and pop in the same cycle: q_count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if !q_empty && transmit && inter_ready → latch head into ctrl_* regs, go to ISSUE.
  - ISSUE: ctrl_en=1 for exactly this one cycle; counter←0; go to WAIT_BUSY.
  - WAIT_BUSY:
    - inter_ready==0 → WAIT_DONE.
    - Else counter++; when counter==BUSY_TIMEOUT-1 → pop, IDLE.
  - WAIT_DONE: inter_ready==1 → pop, IDLE.
- Latency:
  - Push into an empty queue with transmit && inter_ready high: the push edge is cycle 0; state enters ISSUE at cycle 1; ctrl_en is high during cycle 1.
  - Minimum spacing between consecutive ctrl_en pulses is 4 cycles: ISSUE, WAIT_BUSY, WAIT_DONE, IDLE.
- transmit falls while in WAIT_*: keep waiting; the in-flight message is not re-sent.
- transmit low in IDLE: hold; the queue keeps accepting pushes.
- ctrl_* fields change only in IDLE on issue, or on reset. Never combinationally driven from the FIFO read port.
- q_full, q_empty and q_count are registered and consistent with each other every cycle.

Decomposition:
- Package interboard_pkg:
  - field widths (DIR_W=1, BX_W=5, BY_W=3, MT_W=4, CARD_W=6, SL_W=3);
  - MSG_W=22;
  - pack/unpack functions;
  - FSM state encoding (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE).
- Sub-module interboard_msg_fifo:
  - parameterised synchronous FIFO (DEPTH × MSG_W);
  - push/pop/count/full/empty;
  - first-word-fall-through read port;
  - flush input driven by rst|interboard_rst.
- The FSM and output registers live in the top of this block.

Test Plan:
- Single message: transmit=1, inter_ready=1; push {dir=1,bx=17,by=5,mt=3,card=42,sl=2} → ctrl_en high exactly 1 cycle, one cycle after the push. Model drops inter_ready 1 cycle later and raises it 20 cycles later → pop; q_empty=1; ctrl_* hold 17/5/3/42/2 throughout.
- Burst: 5 pushes on consecutive cycles, DEPTH=4, inter_ready held low → q_full=1, q_count=4, overflow=1. Raise inter_ready → exactly 4 ctrl_en pulses, FIFO order, the 5th push never issued.
- Push while full on the pop cycle → accepted, q_count stays 4, overflow stays 0.
- Timeout: inter_ready stays 1 after ctrl_en → pop after BUSY_TIMEOUT=4 cycles; the next message is issued.
- transmit=0 with 2 queued → no ctrl_en. transmit→1 → 2 pulses, ≥4 cycles apart.
- interboard_rst pulse during WAIT_DONE with 3 queued → next cycle q_count=0, ctrl_en=0, ctrl_*=0, overflow=0; a subsequent push issues normally.
